// File: rtl/ps2_scan_sequencer.sv
// PS/2 byte stream to key events: E0/F0 prefix FSM feeding a small FWFT FIFO.
// Optional SEQ_TIMEOUT_EN builds a prefix timeout counter.
module ps2_scan_sequencer #(
  parameter int FIFO_AW        = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               rx_done_tick,
  input  logic [7:0]         din,
  input  logic               key_ack,
  output logic               rx_en,
  output logic               key_valid,
  output logic [7:0]         key_code,
  output logic               key_ext,
  output logic               key_brk,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               overflow,
  output logic               err_tick,
  output logic               busy
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic is_e0, is_f0, is_bad;
  logic tmo;
  logic push;
  logic err_d, err_q;
  logic [9:0] entry;

  logic [9:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0]   level_q, level_d;
  logic [9:0]         hold_q, hold_d;
  logic               ovf_q, ovf_d;
  logic               full, pop, wr;
  logic [9:0]         head;

  assign is_e0  = din == 8'hE0;
  assign is_f0  = din == 8'hF0;
  assign is_bad = (din == 8'h00) || (din == 8'hFF);

`ifdef SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] cnt_q, cnt_d;

  assign tmo = !rx_done_tick && (state_q != IDLE)
            && (cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (rx_done_tick || tmo)
      cnt_d = '0;
    else if (state_q != IDLE)
      cnt_d = cnt_q + TW'(1);
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (rx_done_tick) begin
      unique case (1'b1)
        is_bad: state_d = IDLE;
        is_e0:  state_d = EXT;
        is_f0: begin
          if (state_q == IDLE)     state_d = BRK;
          else if (state_q == EXT) state_d = EXT_BRK;
        end
        default: state_d = IDLE;
      endcase
    end else if (tmo) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    busy  = state_q != IDLE;
    push  = rx_done_tick && !is_bad && !is_e0 && !is_f0;
    entry = {(state_q == EXT) || (state_q == EXT_BRK),
             (state_q == BRK) || (state_q == EXT_BRK),
             din};
    err_d = tmo;
    if (rx_done_tick) begin
      if (is_bad)
        err_d = 1'b1;
      else if ((is_e0 || is_f0)
            && ((state_q == BRK) || (state_q == EXT_BRK)))
        err_d = 1'b1;
    end
  end

  assign full      = level_q == (FIFO_AW+1)'(DEPTH);
  assign key_valid = level_q != '0;
  assign pop       = key_valid && key_ack;
  // Full FIFO still accepts a write when the head leaves this cycle.
  assign wr        = push && (!full || pop);
  assign head      = key_valid ? mem_q[rd_ptr_q] : hold_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q + FIFO_AW'(pop);
    wr_ptr_d = wr_ptr_q + FIFO_AW'(wr);
    level_d  = level_q;
    unique case ({wr, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    ovf_d  = ovf_q || (push && full && !pop);
    hold_d = head;
  end

  always_ff @(posedge CLK) begin
    if (wr) mem_q[wr_ptr_q] <= entry;
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      hold_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      hold_q   <= hold_d;
      err_q    <= err_d;
    end
  end

  assign rx_en      = !full;
  assign key_ext    = head[9];
  assign key_brk    = head[8];
  assign key_code   = head[7:0];
  assign fifo_level = level_q;
  assign overflow   = ovf_q;
  assign err_tick   = err_q;

endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// Bench for ps2_scan_sequencer: directed byte streams, event scoreboard.
// Honors SEQ_TIMEOUT_EN for the timeout scenario.
module tb_ps2_scan_sequencer;

  logic       CLK = 1'b0;
  logic       reset = 1'b0;
  logic       rx_done_tick = 1'b0;
  logic [7:0] din = 8'h00;
  logic       key_ack = 1'b0;
  logic       rx_en;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_brk;
  logic [2:0] fifo_level;
  logic       overflow;
  logic       err_tick;
  logic       busy;

  int pass_cnt = 0;
  int total_cnt = 0;
  int err_seen = 0;
  int err_base;
  logic [9:0] exp_q[$];

  ps2_scan_sequencer #(
    .FIFO_AW(2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK(CLK),
    .reset(reset),
    .rx_done_tick(rx_done_tick),
    .din(din),
    .key_ack(key_ack),
    .rx_en(rx_en),
    .key_valid(key_valid),
    .key_code(key_code),
    .key_ext(key_ext),
    .key_brk(key_brk),
    .fifo_level(fifo_level),
    .overflow(overflow),
    .err_tick(err_tick),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  function automatic void chk(string name, int act, int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  // Scoreboard monitor: compare each popped head against the queue.
  always @(negedge CLK) begin
    if (err_tick) err_seen++;
    if (reset && key_valid && key_ack) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {22'd0, key_ext, key_brk, key_code}, -1);
      end else begin
        chk("event", {22'd0, key_ext, key_brk, key_code},
            {22'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic send(input logic [7:0] b);
    rx_done_tick = 1'b1;
    din = b;
    @(posedge CLK); #1;
    rx_done_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    key_ack = 1'b1;
    while (key_valid && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    key_ack = 1'b0;
    chk("drain_done", key_valid, 0);
  endtask

  function automatic int rst_vec();
    return {14'd0, rx_en, key_valid, key_code, key_ext, key_brk,
            fifo_level, overflow, err_tick, busy};
  endfunction

  localparam int RST_EXP = 32'h0002_0000;

  initial begin
    idle(3);
    chk("reset_state", rst_vec(), RST_EXP);
    reset = 1'b1;
    idle(1);

    send(8'h1C); exp_q.push_back({2'b00, 8'h1C});
    chk("lat_valid", key_valid, 1);
    chk("level_1", fifo_level, 1);
    send(8'hF0);
    chk("busy_brk", busy, 1);
    send(8'h1C); exp_q.push_back({2'b01, 8'h1C});
    chk("level_2", fifo_level, 2);
    drain();

    send(8'hE0);
    chk("busy_e0", busy, 1);
    send(8'hF0);
    chk("busy_e0f0", busy, 1);
    send(8'h75); exp_q.push_back({2'b11, 8'h75});
    chk("busy_done", busy, 0);
    drain();

    send(8'h15); exp_q.push_back({2'b00, 8'h15});
    send(8'h16); exp_q.push_back({2'b00, 8'h16});
    send(8'h17); exp_q.push_back({2'b00, 8'h17});
    chk("rx_en_3", rx_en, 1);
    send(8'h18); exp_q.push_back({2'b00, 8'h18});
    chk("rx_en_full", rx_en, 0);
    chk("ovf_before", overflow, 0);
    send(8'h19);
    chk("ovf_set", overflow, 1);
    chk("level_full", fifo_level, 4);
    key_ack = 1'b1;
    exp_q.push_back({2'b00, 8'h1A});
    send(8'h1A);
    key_ack = 1'b0;
    chk("level_pushpop", fifo_level, 4);
    drain();
    chk("ovf_sticky", overflow, 1);
    chk("hold_code", {key_ext, key_brk, key_code}, 10'h01A);
    chk("rx_en_empty", rx_en, 1);

    err_base = err_seen;
    send(8'hF0);
    send(8'hE0);
    send(8'h6B); exp_q.push_back({2'b10, 8'h6B});
    idle(1);
    chk("err_once", err_seen - err_base, 1);
    drain();
    send(8'hFF);
    idle(2);
    chk("ff_no_event", fifo_level, 0);
    chk("ff_err", err_seen - err_base, 2);
    send(8'hE0);
    send(8'h00);
    chk("bad_to_idle", busy, 0);
    idle(2);
    chk("bad_err", err_seen - err_base, 3);

    err_base = err_seen;
    send(8'hE0);
    idle(20);
`ifdef SEQ_TIMEOUT_EN
    send(8'h1C); exp_q.push_back({2'b00, 8'h1C});
    idle(1);
    chk("tmo_err", err_seen - err_base, 1);
`else
    chk("no_tmo_busy", busy, 1);
    send(8'h1C); exp_q.push_back({2'b10, 8'h1C});
    idle(1);
    chk("no_tmo_err", err_seen - err_base, 0);
`endif
    drain();

    send(8'h21);
    send(8'h22);
    send(8'h23);
    send(8'hF0);
    chk("pre_rst_level", fifo_level, 3);
    chk("pre_rst_busy", busy, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset", rst_vec(), RST_EXP);
    idle(2);
    reset = 1'b1;
    idle(1);
    send(8'h2A); exp_q.push_back({2'b00, 8'h2A});
    drain();
    chk("sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
